// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage; owns the PC, issues word reads, queues
//               responses in order and hands (ir, pc) to decode. Handles
//               redirect flush/drop and sticky halt.
//               Optional: FETCH_PERF_CNT_EN adds perf_fetched/dropped/stall.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [31:0] pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped,
    output logic [31:0] perf_stall
`endif
);

    localparam int          c_AW    = $clog2(QUEUE_DEPTH);
    localparam int          c_CW    = c_AW + 1;
    localparam logic [c_CW:0] c_DEPTH = (c_CW + 1)'(QUEUE_DEPTH);
    localparam logic [31:0] c_NOP   = 32'h0000_0013;

    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_pend_pc [QUEUE_DEPTH];
    logic [c_AW-1:0] r_pend_wr;
    logic [c_AW-1:0] r_pend_rd;
    logic [31:0]     r_q_ir [QUEUE_DEPTH];
    logic [31:0]     r_q_pc [QUEUE_DEPTH];
    logic [c_AW-1:0] r_q_wr;
    logic [c_AW-1:0] r_q_rd;
    logic [c_CW-1:0] r_q_count;
    logic [c_CW-1:0] r_outstanding;
    logic [c_CW-1:0] r_drop_cnt;
    logic            r_halted;
    logic [31:0]     r_last_pc;

    logic            w_flush;
    logic            w_redir;
    logic            w_accept;
    logic            w_dropping;
    logic            w_pend_pop;
    logic            w_push;
    logic            w_pop;
    logic [c_CW-1:0] w_out_next;
    logic            w_unused;

    assign w_unused = &{1'b0, redirect_pc[1:0]};

    // A redirect or halt while already halted has no effect.
    assign w_redir    = !r_halted && redirect;
    assign w_flush    = !r_halted && (redirect || halt);
    assign w_dropping = (r_drop_cnt != '0);

    assign imem_req_valid = !rst && !r_halted && !redirect &&
                            (({1'b0, r_outstanding} + {1'b0, r_q_count}) < c_DEPTH);
    assign imem_addr      = r_fetch_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    assign w_pend_pop = imem_rsp_valid && !w_dropping;
    assign w_push     = w_pend_pop && !w_flush && !r_halted;
    assign ir_valid   = (r_q_count != '0);
    assign w_pop      = ir_valid && ir_ready && !w_flush;
    assign ir         = ir_valid ? r_q_ir[r_q_rd] : c_NOP;
    assign pc         = ir_valid ? r_q_pc[r_q_rd] : r_last_pc;

    // Responses are always retired from the outstanding count, kept or not.
    assign w_out_next = r_outstanding + c_CW'(w_accept) - c_CW'(imem_rsp_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_pend_wr     <= '0;
            r_pend_rd     <= '0;
            r_q_wr        <= '0;
            r_q_rd        <= '0;
            r_q_count     <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_halted      <= 1'b0;
            r_last_pc     <= RESET_PC;
        end else begin
            r_outstanding <= w_out_next;
            if (ir_valid) begin
                r_last_pc <= r_q_pc[r_q_rd];
            end

            if (w_redir) begin
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end

            if (w_flush) begin
                r_halted   <= r_halted || halt;
                r_pend_wr  <= '0;
                r_pend_rd  <= '0;
                r_q_wr     <= '0;
                r_q_rd     <= '0;
                r_q_count  <= '0;
                // Every request still in flight (including any accepted now)
                // becomes stale; a response arriving now is already discarded.
                r_drop_cnt <= w_out_next;
            end else begin
                if (imem_rsp_valid && w_dropping) begin
                    r_drop_cnt <= r_drop_cnt - 1'b1;
                end
                if (w_accept) begin
                    r_pend_wr <= r_pend_wr + 1'b1;
                end
                if (w_pend_pop) begin
                    r_pend_rd <= r_pend_rd + 1'b1;
                end
                if (w_push) begin
                    r_q_wr <= r_q_wr + 1'b1;
                end
                if (w_pop) begin
                    r_q_rd <= r_q_rd + 1'b1;
                end
                r_q_count <= r_q_count + c_CW'(w_push) - c_CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pend_pc[r_pend_wr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_q_ir[r_q_wr] <= imem_rdata;
            r_q_pc[r_q_wr] <= r_pend_pc[r_pend_rd];
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(w_push && !w_pop && ({1'b0, r_q_count} == c_DEPTH)));
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_dropped;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_dropped <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_push) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (imem_rsp_valid && !w_push) begin
                r_perf_dropped <= r_perf_dropped + 32'd1;
            end
            if (!ir_valid && !r_halted) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_dropped = r_perf_dropped;
    assign perf_stall   = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit with a latency-programmable
//               memory model and a second instance for PC wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect, halt, ir_valid, ir_ready;
    logic [31:0] redirect_pc, ir, pc;

    logic        req_valid2, rsp_valid2, ir_valid2;
    logic [31:0] addr2, ir2, pc2;
    logic        req_ready2, ir_ready2, redirect2, halt2;
    logic [31:0] rdata2, redirect_pc2;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .pc(pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid2), .imem_req_ready(req_ready2),
        .imem_addr(addr2), .imem_rsp_valid(rsp_valid2), .imem_rdata(rdata2),
        .redirect(redirect2), .redirect_pc(redirect_pc2), .halt(halt2),
        .ir_valid(ir_valid2), .ir_ready(ir_ready2), .ir(ir2), .pc(pc2)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] ir; } out_t;

    mreq_t       mq[$];
    logic [31:0] exp_addr[$];
    out_t        exp_out[$];
    logic [31:0] a2[$];
    int          lat = 1;
    int          budget = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_budget(input int n);
        budget         = n;
        imem_req_ready = (n > 0);
    endtask

    task automatic expect_fetch(input logic [31:0] a, input bit delivered);
        exp_addr.push_back(a);
        if (delivered) exp_out.push_back('{a, memf(a)});
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while ((exp_out.size() != 0 || exp_addr.size() != 0) && n < maxc) begin
            @(posedge clk); #2;
            n++;
        end
        chk("drain_left", 32'(exp_out.size() + exp_addr.size()), 32'd0);
    endtask

    task automatic wait_acc(input int target, input int maxc);
        int n = 0;
        while (acc_cnt < target && n < maxc) begin
            @(posedge clk); #2;
            n++;
        end
        chk("accept_count", 32'(acc_cnt), 32'(target));
    endtask

    // Memory model: in-order, fixed latency, grants up to 'budget' requests.
    initial begin
        bit          s_acc, s_rsp, s_rst;
        logic [31:0] s_addr;
        imem_rsp_valid = 1'b0;
        imem_rdata     = '0;
        imem_req_ready = 1'b0;
        forever begin
            @(posedge clk);
            s_acc  = imem_req_valid && imem_req_ready;
            s_addr = imem_addr;
            s_rsp  = imem_rsp_valid;
            s_rst  = rst;
            #1;
            if (s_rst) begin
                mq.delete();
                imem_rsp_valid = 1'b0;
            end else begin
                cyc++;
                if (s_rsp) void'(mq.pop_front());
                if (s_acc) begin
                    acc_cnt++;
                    budget--;
                    imem_req_ready = (budget > 0);
                    mq.push_back('{s_addr, cyc - 1 + lat});
                    if (exp_addr.size() == 0) chk("unexpected_req", s_addr, 32'hXXXX_XXXX);
                    else chk("req_addr", s_addr, exp_addr.pop_front());
                end
                if (mq.size() > 0 && mq[0].due <= cyc) begin
                    imem_rsp_valid = 1'b1;
                    imem_rdata     = memf(mq[0].addr);
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rdata     = '0;
                end
            end
        end
    end

    // Output monitor: every handshake is checked against the scoreboard.
    initial begin
        bit          s_hs;
        logic [31:0] s_ir, s_pc;
        out_t        e;
        forever begin
            @(posedge clk);
            s_hs = !rst && ir_valid && ir_ready;
            s_ir = ir;
            s_pc = pc;
            if (s_hs) begin
                if (exp_out.size() == 0) begin
                    chk("unexpected_out_pc", s_pc, 32'hXXXX_XXXX);
                end else begin
                    e = exp_out.pop_front();
                    chk("out_pc", s_pc, e.pc);
                    chk("out_ir", s_ir, e.ir);
                end
            end
        end
    end

    // Second instance: always-ready memory with latency 1, log first addresses.
    initial begin
        bit s_acc2;
        rsp_valid2 = 1'b0; rdata2 = '0; req_ready2 = 1'b1; ir_ready2 = 1'b1;
        redirect2 = 1'b0; redirect_pc2 = '0; halt2 = 1'b0;
        forever begin
            @(posedge clk);
            s_acc2 = req_valid2 && req_ready2;
            if (s_acc2 && a2.size() < 3) a2.push_back(addr2);
            #1;
            rsp_valid2 = s_acc2;
        end
    end

    initial begin
        int a0;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0; ir_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_ir", ir, c_NOP);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc2", pc2, 32'hFFFF_FFF8);
        rst = 1'b0;

        // Sequential fetch, latency 1
        expect_fetch(32'h0, 1); expect_fetch(32'h4, 1); expect_fetch(32'h8, 1);
        set_budget(3);
        @(posedge clk); #2;
        chk("lat_ir_valid_early", 32'(ir_valid), 32'd0);
        @(posedge clk); #2;
        chk("lat_ir_valid", 32'(ir_valid), 32'd1);
        chk("lat_pc", pc, 32'h0);
        wait_drain(50);
        chk("empty_ir_nop", ir, c_NOP);
        chk("empty_pc_hold", pc, 32'h8);

        // Decoder back-pressure: only QUEUE_DEPTH requests outstanding
        ir_ready = 1'b0;
        expect_fetch(32'hC, 1); expect_fetch(32'h10, 1);
        expect_fetch(32'h14, 1); expect_fetch(32'h18, 1);
        a0 = acc_cnt;
        set_budget(4);
        repeat (10) @(posedge clk);
        #2;
        chk("bp_accepts", 32'(acc_cnt - a0), 32'd2);
        chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
        chk("bp_head_pc", pc, 32'hC);
        ir_ready = 1'b1;
        wait_drain(50);

        // Latency 3, two in flight, redirect drops both
        lat = 3;
        expect_fetch(32'h1C, 0); expect_fetch(32'h20, 0);
        a0 = acc_cnt;
        set_budget(2);
        wait_acc(a0 + 2, 20);
        redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
        @(posedge clk); #2;
        redirect = 1'b0;
        expect_fetch(32'h100, 1);
        set_budget(1);
        wait_drain(50);
        lat = 1;

        // Redirect to unaligned target in the same cycle a response arrives
        expect_fetch(32'h104, 0);
        expect_fetch(32'h100, 1); expect_fetch(32'h104, 1);
        set_budget(3);
        @(posedge clk); #2;
        chk("same_cycle_rsp", 32'(imem_rsp_valid), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h103;
        #1;
        chk("redir2_req_valid", 32'(imem_req_valid), 32'd0);
        @(posedge clk); #2;
        redirect = 1'b0;
        chk("redir2_addr", imem_addr, 32'h100);
        wait_drain(50);

        // Halt with a full queue
        ir_ready = 1'b0;
        expect_fetch(32'h108, 0); expect_fetch(32'h10C, 0);
        set_budget(2);
        repeat (6) @(posedge clk);
        #2;
        chk("pre_halt_ir_valid", 32'(ir_valid), 32'd1);
        halt = 1'b1;
        @(posedge clk); #2;
        halt = 1'b0;
        ir_ready = 1'b1;
        a0 = acc_cnt;
        set_budget(5);
        chk("halt_ir_valid", 32'(ir_valid), 32'd0);
        chk("halt_ir", ir, c_NOP);
        repeat (4) @(posedge clk);
        #2;
        chk("halt_req_valid", 32'(imem_req_valid), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h200;
        @(posedge clk); #2;
        redirect = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("halt_redir_req_valid", 32'(imem_req_valid), 32'd0);
        chk("halt_redir_ir_valid", 32'(ir_valid), 32'd0);
        chk("halt_accepts", 32'(acc_cnt - a0), 32'd0);
        set_budget(0);

        // PC wrap on the second instance
        chk("wrap_count", 32'(a2.size()), 32'd3);
        if (a2.size() == 3) begin
            chk("wrap_a0", a2[0], 32'hFFFF_FFF8);
            chk("wrap_a1", a2[1], 32'hFFFF_FFFC);
            chk("wrap_a2", a2[2], 32'h0000_0000);
        end

        chk("sb_out_left", 32'(exp_out.size()), 32'd0);
        chk("sb_addr_left", 32'(exp_addr.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
